// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
//   Shared definitions for the program-counter slice of the single-cycle
//   MIPS core:
//     PC_W       default PC / address width
//     RESET_VEC  default PC loaded on reset
//     EXC_VEC    default PC loaded when a misaligned JR target is detected
//     state_t    PC sequencer states (HOLD, RUN, FAULT)
//     sext16     sign-extends a 16-bit immediate to 32 bits
// ---------------------------------------------------------------------------
package pc_pkg;

  localparam int          PC_W      = 32;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_0180;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// ---------------------------------------------------------------------------
// pc_target_calc
//   Purely combinational candidate-target generator for the next-PC select.
//   Ports:
//     pc            in   current PC
//     imm16         in   signed branch offset, in words
//     jidx26        in   J/JAL instruction index
//     rs_val        in   JR target register value
//     pc_plus4      out  pc + 4 (wraps mod 2^PC_W)
//     br_target     out  pc + 4 + (sext(imm16) << 2)
//     j_target      out  {pc_plus4[31:28], jidx26, 2'b00}
//     rs_misaligned out  1 when rs_val is not word aligned
// ---------------------------------------------------------------------------
module pc_target_calc #(
  parameter int PC_W = pc_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm16,
  input  logic [25:0]     jidx26,
  input  logic [PC_W-1:0] rs_val,
  output logic [PC_W-1:0] pc_plus4,
  output logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] j_target,
  output logic            rs_misaligned
);

  import pc_pkg::*;

  logic [PC_W-1:0] imm_sext;
  logic [PC_W-1:0] imm_bytes;

  assign imm_sext  = sext16(imm16);
  // Word offset to byte offset; the top two sign bits fall off, which is
  // exactly the mod-2^32 behaviour the add below needs.
  assign imm_bytes = {imm_sext[PC_W-3:0], 2'b00};

  assign pc_plus4  = pc + PC_W'(4);
  assign br_target = pc_plus4 + imm_bytes;
  // The 256 MB region comes from the delay-slot address (pc+4), not pc.
  assign j_target  = {pc_plus4[PC_W-1:28], jidx26, 2'b00};

  assign rs_misaligned = |rs_val[1:0];

endmodule

// File: rtl/pc_next_unit.sv
// ---------------------------------------------------------------------------
// pc_next_unit
//   Program-counter register and next-PC select for the single-cycle MIPS
//   core. Resolves BEQ/BNE, J/JAL and JR, adds a one-cycle hold after reset,
//   a global stall, and a sticky FAULT state entered on a misaligned JR.
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     stall      in   1 = freeze PC and all state this cycle
//     zero       in   ALU zero flag
//     branch_eq  in   decoded BEQ
//     branch_ne  in   decoded BNE
//     jump       in   decoded J/JAL
//     jump_reg   in   decoded JR
//     imm16      in   branch offset in words (signed)
//     jidx26     in   jump instruction index
//     rs_val     in   JR target
//     fault_clr  in   leave FAULT state
//     pc         out  current PC (registered)
//     pc_plus4   out  pc + 4 (combinational, JAL link value)
//     br_taken   out  last PC update was a taken branch/jump (registered)
//     fault      out  FAULT state active (registered)
// ---------------------------------------------------------------------------
module pc_next_unit #(
  parameter int              PC_W      = pc_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_VEC = pc_pkg::RESET_VEC,
  parameter logic [PC_W-1:0] EXC_VEC   = pc_pkg::EXC_VEC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            zero,
  input  logic            branch_eq,
  input  logic            branch_ne,
  input  logic            jump,
  input  logic            jump_reg,
  input  logic [15:0]     imm16,
  input  logic [25:0]     jidx26,
  input  logic [PC_W-1:0] rs_val,
  input  logic            fault_clr,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            br_taken,
  output logic            fault
);

  import pc_pkg::*;

  state_t          state_reg;
  logic [PC_W-1:0] pc_reg;
  logic            br_taken_reg;
  logic            fault_reg;

  logic [PC_W-1:0] pc_plus4_w;
  logic [PC_W-1:0] br_target_w;
  logic [PC_W-1:0] j_target_w;
  logic            rs_misaligned_w;

  logic [PC_W-1:0] pc_next;
  logic            taken_next;

  pc_target_calc #(
    .PC_W (PC_W)
  ) u_target_calc (
    .pc            (pc_reg),
    .imm16         (imm16),
    .jidx26        (jidx26),
    .rs_val        (rs_val),
    .pc_plus4      (pc_plus4_w),
    .br_target     (br_target_w),
    .j_target      (j_target_w),
    .rs_misaligned (rs_misaligned_w)
  );

  // Next-PC priority select. BEQ and BNE asserted together contradict each
  // other, so each branch term requires the other one to be low.
  always_comb begin
    pc_next    = pc_plus4_w;
    taken_next = 1'b0;
    if (jump_reg) begin
      pc_next    = rs_val;
      taken_next = 1'b1;
    end else if (jump) begin
      pc_next    = j_target_w;
      taken_next = 1'b1;
    end else if (branch_eq && !branch_ne && zero) begin
      pc_next    = br_target_w;
      taken_next = 1'b1;
    end else if (branch_ne && !branch_eq && !zero) begin
      pc_next    = br_target_w;
      taken_next = 1'b1;
    end
  end

  // Sequencer. stall freezes every register, including the FAULT exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= HOLD;
      pc_reg       <= RESET_VEC;
      br_taken_reg <= 1'b0;
      fault_reg    <= 1'b0;
    end else if (!stall) begin
      case (state_reg)
        HOLD: begin
          state_reg    <= RUN;
          br_taken_reg <= 1'b0;
        end
        RUN: begin
          if (jump_reg && rs_misaligned_w) begin
            state_reg    <= FAULT;
            pc_reg       <= EXC_VEC;
            br_taken_reg <= 1'b0;
            fault_reg    <= 1'b1;
          end else begin
            pc_reg       <= pc_next;
            br_taken_reg <= taken_next;
          end
        end
        FAULT: begin
          // Decode inputs (including another bad JR) are ignored here.
          br_taken_reg <= 1'b0;
          if (fault_clr) begin
            state_reg <= RUN;
            pc_reg    <= EXC_VEC + PC_W'(4);
            fault_reg <= 1'b0;
          end
        end
        default: begin
          state_reg    <= HOLD;
          pc_reg       <= RESET_VEC;
          br_taken_reg <= 1'b0;
          fault_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign pc       = pc_reg;
  assign pc_plus4 = pc_plus4_w;
  assign br_taken = br_taken_reg;
  assign fault    = fault_reg;

endmodule
